// File: rtl/if_net_pkg.sv
// Shared types and constant helpers for the clocked IF network: sizing
// functions, address-width derivation, saturating add and the FSM state enum.
package if_net_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    // Never returns 0 so that derived field widths stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        return max2(max2(a, b), c);
    endfunction

    function automatic int addr_w(input int n_in, input int n_hid, input int n_out,
                                  input int n_hid_layers);
        return clog2(n_hid_layers + 2) + 2 * clog2(max3(n_in, n_hid, n_out));
    endfunction

    function automatic int layer_pre(input int k, input int n_in, input int n_hid);
        return (k == 0) ? n_in : n_hid;
    endfunction

    function automatic int layer_post(input int k, input int n_hid_layers, input int n_hid,
                                      input int n_out);
        return (k == n_hid_layers + 1) ? n_out : n_hid;
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input int bits);
        longint s, hi, lo;
        s  = a + b;
        hi = (longint'(1) <<< (bits - 1)) - 1;
        lo = -(longint'(1) <<< (bits - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/if_neuron_unit.sv
// One integrate-and-fire neuron: membrane, refractory counter and spike register.
// Defining IF_NET_LEAK_EN adds a per-step decay of LEAK toward zero (LIF).
module if_neuron_unit
    import if_net_pkg::*;
#(
    parameter int THRESH    = 15,
    parameter int RESET     = 0,
    parameter int REFRAC    = 5,
    parameter int VMEM_SIZE = 16,
    parameter int SUM_W     = 18,
    parameter int LEAK      = 1
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    clear,
    input  logic                    en,
    input  logic signed [SUM_W-1:0] sum,
    output logic                    spike
);
    localparam int RW = clog2(REFRAC + 1);
    localparam logic signed [VMEM_SIZE-1:0] THRESH_V = VMEM_SIZE'(THRESH);
    localparam logic signed [VMEM_SIZE-1:0] RESET_V  = VMEM_SIZE'(RESET);

    logic signed [VMEM_SIZE-1:0] vmem_reg;
    logic [RW-1:0]               refrac_reg;
    logic                        spike_reg;
    logic signed [VMEM_SIZE-1:0] leak_v;
    logic signed [VMEM_SIZE-1:0] vmem_next;

`ifdef IF_NET_LEAK_EN
    localparam logic signed [VMEM_SIZE-1:0] LEAK_V = VMEM_SIZE'(LEAK);
`else
    // LEAK has no effect in the pure IF build.
    localparam int leak_unused = LEAK;
`endif

    always_comb begin
        leak_v = vmem_reg;
`ifdef IF_NET_LEAK_EN
        if (vmem_reg > LEAK_V)
            leak_v = vmem_reg - LEAK_V;
        else if (vmem_reg < -LEAK_V)
            leak_v = vmem_reg + LEAK_V;
        else
            leak_v = '0;
`endif
        vmem_next = VMEM_SIZE'(sat_add(longint'(leak_v), longint'(sum), VMEM_SIZE));
    end

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            vmem_reg   <= '0;
            refrac_reg <= '0;
            spike_reg  <= 1'b0;
        end else if (en) begin
            if (refrac_reg != '0) begin
                refrac_reg <= refrac_reg - 1'b1;
                spike_reg  <= 1'b0;
            end else if (vmem_next >= THRESH_V) begin
                spike_reg  <= 1'b1;
                vmem_reg   <= RESET_V;
                refrac_reg <= RW'(REFRAC);
            end else begin
                spike_reg  <= 1'b0;
                vmem_reg   <= vmem_next;
            end
        end
    end

    assign spike = spike_reg;

endmodule

// File: rtl/if_network_seq.sv
// Time-stepped, fully connected IF network evaluated one layer per clock with
// programmable weights and valid/ready spike ports. Optional leak: IF_NET_LEAK_EN.
module if_network_seq
    import if_net_pkg::*;
#(
    parameter int THRESH             = 15,
    parameter int RESET              = 0,
    parameter int REFRAC             = 5,
    parameter int WEIGHT_SIZE        = 8,
    parameter int VMEM_SIZE          = 16,
    parameter int NUM_INPUTS         = 4,
    parameter int NUM_OUTPUTS        = 1,
    parameter int NUM_HIDDEN_LAYERS  = 1,
    parameter int NUM_HIDDEN_NEURONS = 4,
    parameter int LEAK               = 1,
    localparam int MAX_W  = max3(NUM_INPUTS, NUM_HIDDEN_NEURONS, NUM_OUTPUTS),
    localparam int IW     = clog2(MAX_W),
    localparam int L      = NUM_HIDDEN_LAYERS + 2,
    localparam int LW     = clog2(L),
    localparam int ADDR_W = addr_w(NUM_INPUTS, NUM_HIDDEN_NEURONS, NUM_OUTPUTS, NUM_HIDDEN_LAYERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [NUM_INPUTS-1:0]  spike_in,
    input  logic                   spike_in_valid,
    output logic                   spike_in_ready,
    output logic [NUM_OUTPUTS-1:0] spike_out,
    output logic                   spike_out_valid,
    input  logic                   spike_out_ready,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WEIGHT_SIZE-1:0] wr_data,
    output logic                   wr_ready,
    output logic                   busy
);
    localparam int SUM_W = VMEM_SIZE + IW;

    state_t                         state_reg;
    logic [LW-1:0]                  layer_reg;
    logic [MAX_W-1:0]               in_reg;
    logic                           spike_out_valid_reg;
    logic signed [WEIGHT_SIZE-1:0]  weight_reg [L][MAX_W][MAX_W];
    logic [L-1:0][MAX_W-1:0]        layer_spk;
    logic                           clear_en;
    logic                           wr_hit;
    logic                           wr_fire;
    logic [LW-1:0]                  wa_layer;
    logic [IW-1:0]                  wa_post;
    logic [IW-1:0]                  wa_pre;
    logic                           spk_unused;

    assign {wa_layer, wa_post, wa_pre} = wr_addr;
    assign clear_en = clear && (state_reg == IDLE);

    always_comb begin
        wr_hit = 1'b0;
        for (int k = 0; k < L; k++) begin
            if (int'(wa_layer) == k &&
                int'(wa_post) < layer_post(k, NUM_HIDDEN_LAYERS, NUM_HIDDEN_NEURONS, NUM_OUTPUTS) &&
                int'(wa_pre) < layer_pre(k, NUM_INPUTS, NUM_HIDDEN_NEURONS))
                wr_hit = 1'b1;
        end
    end

    assign wr_fire = wr_en && wr_hit && (state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= IDLE;
            layer_reg           <= '0;
            in_reg              <= '0;
            spike_out_valid_reg <= 1'b0;
            for (int k = 0; k < L; k++)
                for (int j = 0; j < MAX_W; j++)
                    for (int i = 0; i < MAX_W; i++)
                        weight_reg[k][j][i] <= '0;
        end else begin
            if (wr_fire)
                weight_reg[wa_layer][wa_post][wa_pre] <= wr_data;
            case (state_reg)
                IDLE: begin
                    // A clear in the same cycle wins; the producer must retry.
                    if (!clear && spike_in_valid) begin
                        in_reg    <= MAX_W'(spike_in);
                        layer_reg <= '0;
                        state_reg <= EVAL;
                    end
                end
                EVAL: begin
                    if (layer_reg == LW'(L - 1)) begin
                        state_reg           <= DONE;
                        spike_out_valid_reg <= 1'b1;
                    end else begin
                        layer_reg <= layer_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (spike_out_ready) begin
                        state_reg           <= IDLE;
                        spike_out_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Each layer slot keeps its own neurons; layer k reads layer k-1's registered spikes.
    for (genvar gi = 0; gi < L; gi++) begin : g_layer
        localparam int POST = layer_post(gi, NUM_HIDDEN_LAYERS, NUM_HIDDEN_NEURONS, NUM_OUTPUTS);
        logic [MAX_W-1:0] layer_in;
        logic             layer_en;

        if (gi == 0) begin : g_src_in
            assign layer_in = in_reg;
        end else begin : g_src_prev
            assign layer_in = layer_spk[gi-1];
        end
        assign layer_en = (state_reg == EVAL) && (layer_reg == LW'(gi));

        for (genvar gj = 0; gj < MAX_W; gj++) begin : g_post
            logic signed [SUM_W-1:0] syn_sum;
            logic                    slot_en;

            // Out-of-range weights can never be written, so they contribute zero.
            always_comb begin
                syn_sum = '0;
                for (int i = 0; i < MAX_W; i++)
                    if (layer_in[i])
                        syn_sum = syn_sum + SUM_W'(weight_reg[gi][gj][i]);
            end

            assign slot_en = (gj < POST) ? layer_en : 1'b0;

            if_neuron_unit #(
                .THRESH   (THRESH),
                .RESET    (RESET),
                .REFRAC   (REFRAC),
                .VMEM_SIZE(VMEM_SIZE),
                .SUM_W    (SUM_W),
                .LEAK     (LEAK)
            ) u_neuron (
                .clk  (clk),
                .srst (rst),
                .clear(clear_en),
                .en   (slot_en),
                .sum  (syn_sum),
                .spike(layer_spk[gi][gj])
            );
        end
    end

    assign spk_unused      = ^layer_spk[L-1];
    assign spike_out       = layer_spk[L-1][NUM_OUTPUTS-1:0];
    assign spike_out_valid = spike_out_valid_reg;
    assign spike_in_ready  = (state_reg == IDLE);
    assign wr_ready        = (state_reg == IDLE);
    assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_if_network_seq.sv
// Randomised and directed bench for if_network_seq (VMEM_SIZE=8) against a
// behavioural timestep model held in plain integer arrays.
module tb_if_network_seq;
    localparam int NL = 3;
    localparam int MW = 4;
    localparam int AW = 6;
    localparam int VMAX = 127;
    localparam int VMIN = -128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [3:0]    spike_in = '0;
    logic          spike_in_valid = 1'b0;
    logic          spike_in_ready;
    logic [0:0]    spike_out;
    logic          spike_out_valid;
    logic          spike_out_ready = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          wr_ready;
    logic          busy;

    int errors = 0;
    int checks = 0;

    int m_w [NL][MW][MW];
    int m_v [NL][MW];
    int m_r [NL][MW];

    always #5 clk = ~clk;

    if_network_seq #(.VMEM_SIZE(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .spike_in       (spike_in),
        .spike_in_valid (spike_in_valid),
        .spike_in_ready (spike_in_ready),
        .spike_out      (spike_out),
        .spike_out_valid(spike_out_valid),
        .spike_out_ready(spike_out_ready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int post_n(input int k);
        return (k == NL - 1) ? 1 : 4;
    endfunction

    task automatic m_clear;
        for (int k = 0; k < NL; k++)
            for (int j = 0; j < MW; j++) begin
                m_v[k][j] = 0;
                m_r[k][j] = 0;
            end
    endtask

    task automatic m_reset;
        m_clear();
        for (int k = 0; k < NL; k++)
            for (int j = 0; j < MW; j++)
                for (int i = 0; i < MW; i++)
                    m_w[k][j][i] = 0;
    endtask

    task automatic m_step(input logic [3:0] in, output logic out);
        int pre [MW];
        int nxt [MW];
        int v;
        for (int i = 0; i < MW; i++) pre[i] = in[i];
        for (int k = 0; k < NL; k++) begin
            for (int j = 0; j < MW; j++) begin
                nxt[j] = 0;
                if (j < post_n(k)) begin
                    if (m_r[k][j] > 0) begin
                        m_r[k][j]--;
                    end else begin
                        v = m_v[k][j];
`ifdef IF_NET_LEAK_EN
                        if (v > 0) v = (v > 1) ? v - 1 : 0;
                        else if (v < 0) v = (v < -1) ? v + 1 : 0;
`endif
                        for (int i = 0; i < MW; i++) v += pre[i] * m_w[k][j][i];
                        if (v > VMAX) v = VMAX;
                        if (v < VMIN) v = VMIN;
                        if (v >= 15) begin
                            nxt[j] = 1;
                            m_v[k][j] = 0;
                            m_r[k][j] = 5;
                        end else begin
                            m_v[k][j] = v;
                        end
                    end
                end
            end
            for (int j = 0; j < MW; j++) pre[j] = nxt[j];
        end
        out = pre[0][0];
    endtask

    task automatic do_write(input int layer, input int post, input int pre, input int data);
        logic [1:0] lf, pf, qf;
        lf = layer[1:0];
        pf = post[1:0];
        qf = pre[1:0];
        check("wr_ready", wr_ready, 1);
        wr_en   = 1'b1;
        wr_addr = {lf, pf, qf};
        wr_data = data[7:0];
        tick();
        wr_en = 1'b0;
        if (layer < NL && post < post_n(layer) && pre < MW)
            m_w[layer][post][pre] = $signed(wr_data);
    endtask

    task automatic set_layer(input int layer, input int data);
        for (int j = 0; j < post_n(layer); j++)
            for (int i = 0; i < MW; i++)
                do_write(layer, j, i, data);
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_clear();
    endtask

    task automatic run_step(input logic [3:0] in, input int hold);
        logic exp_o;
        int   n;
        m_step(in, exp_o);
        check("in_ready_idle", spike_in_ready, 1);
        spike_in       = in;
        spike_in_valid = 1'b1;
        tick();
        spike_in_valid = 1'b0;
        spike_in       = 4'($urandom);
        check("busy_eval", busy, 1);
        check("in_ready_eval", spike_in_ready, 0);
        n = 1;
        while (!spike_out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", n, NL + 1);
        check("spike_out", spike_out, exp_o);
        for (int h = 0; h < hold; h++) begin
            spike_in_valid = 1'b1;
            wr_en          = 1'b1;
            wr_addr        = AW'($urandom);
            wr_data        = 8'($urandom);
            tick();
            check("hold_valid", spike_out_valid, 1);
            check("hold_data", spike_out, exp_o);
            check("hold_in_ready", spike_in_ready, 0);
            check("hold_wr_ready", wr_ready, 0);
        end
        spike_in_valid  = 1'b0;
        wr_en           = 1'b0;
        spike_out_ready = 1'b1;
        tick();
        spike_out_ready = 1'b0;
        check("valid_drop", spike_out_valid, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        logic [3:0] rin;
        int         op;

        // Reset held for two cycles.
        m_reset();
        tick();
        tick();
        check("rst_spike_out", spike_out, 0);
        check("rst_valid", spike_out_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        check("rst_in_ready", spike_in_ready, 1);
        check("rst_wr_ready", wr_ready, 1);

        // Full propagation, then refractory pattern T2..T7.
        for (int k = 0; k < NL; k++) set_layer(k, 8);
        run_step(4'b1111, 0);
        check("prop_T1", spike_out, 1);
        for (int t = 2; t <= 7; t++) run_step(4'b1111, 0);
        check("refrac_T7", spike_out, 1);

        // Backpressure with dropped writes and ignored inputs.
        do_clear();
        run_step(4'b1111, 10);
        do_clear();
        run_step(4'b1111, 0);

        // Sub-threshold accumulation on the input layer.
        do_clear();
        set_layer(0, 4);
        for (int t = 0; t < 4; t++) run_step(4'b0001, 0);
        check("accum_T4", spike_out, 1);

        // Negative saturation, recovery, then clear racing an accept.
        do_clear();
        set_layer(0, -128);
        set_layer(1, 20);
        set_layer(2, 20);
        for (int t = 0; t < 3; t++) run_step(4'b1111, 0);
        set_layer(0, 35);
        run_step(4'b1111, 0);
        check("sat_no_wrap", spike_out, 0);
        run_step(4'b1111, 0);
        clear          = 1'b1;
        spike_in_valid = 1'b1;
        spike_in       = 4'b1111;
        tick();
        clear          = 1'b0;
        spike_in_valid = 1'b0;
        m_clear();
        check("clear_blocks_accept", busy, 0);
        run_step(4'b1111, 0);

        // Reset during evaluation discards the result and the weights.
        for (int k = 0; k < NL; k++) set_layer(k, 8);
        spike_in       = 4'b1111;
        spike_in_valid = 1'b1;
        tick();
        spike_in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_reset();
        check("midrst_valid", spike_out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_spike_out", spike_out, 0);
        run_step(4'b1111, 0);

        // Random mix of writes, clears and timesteps.
        for (int k = 0; k < NL; k++)
            for (int j = 0; j < post_n(k); j++)
                for (int i = 0; i < MW; i++)
                    do_write(k, j, i, $urandom_range(60) - 20);
        for (int it = 0; it < 120; it++) begin
            op = $urandom_range(9);
            if (op < 2)
                do_write($urandom_range(3), $urandom_range(3), $urandom_range(3),
                         $urandom_range(255) - 128);
            else if (op < 3)
                do_clear();
            else begin
                rin = 4'($urandom);
                run_step(rin, $urandom_range(2));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
